// File: rtl/pgm_ddram_arb.sv
// DDRAM port arbiter for the PGM core: serialises loader writes and video/CPU
// 64-bit reads onto one DDRAM command port, honouring busy and dout_ready.
module pgm_ddram_arb #(
    parameter logic [28:0] ADDR_BASE  = 29'h0600_0000,
    parameter int          STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_req,
    input  logic [26:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_ack,
    input  logic        vid_req,
    input  logic [28:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_valid,
    output logic [63:0] vid_data,
    input  logic        cpu_req,
    input  logic [28:0] cpu_addr,
    output logic        cpu_ack,
    output logic        cpu_valid,
    output logic [63:0] cpu_data,
    output logic        ddram_rd,
    output logic        ddram_we,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic [7:0]  ddram_burstcnt,
    input  logic        ddram_busy,
    input  logic [63:0] ddram_dout,
    input  logic        ddram_dout_ready
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_VID  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic        rd_q, rd_d;
    logic        we_q, we_d;
    logic [28:0] addr_q, addr_d;
    logic [63:0] din_q, din_d;
    logic [7:0]  be_q, be_d;
    logic        vid_valid_q, vid_valid_d;
    logic        cpu_valid_q, cpu_valid_d;
    logic [63:0] vid_data_q, vid_data_d;
    logic [63:0] cpu_data_q, cpu_data_d;
    logic [1:0]  pick;
    logic        accept;

    // Loader always wins; a starved CPU beats video; otherwise video beats CPU.
    always_comb begin
        pick = OWN_NONE;
        if (ld_req)
            pick = OWN_LD;
        else if (cpu_req && (starve_q == STARVE_LIM))
            pick = OWN_CPU;
        else if (vid_req)
            pick = OWN_VID;
        else if (cpu_req)
            pick = OWN_CPU;
    end

    assign accept = (state_q == S_ISSUE) && !ddram_busy;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        rd_d        = rd_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        be_d        = be_q;
        vid_valid_d = 1'b0;
        cpu_valid_d = 1'b0;
        vid_data_d  = vid_data_q;
        cpu_data_d  = cpu_data_q;

        if (!cpu_req)
            starve_d = 4'd0;
        else if (state_q == S_IDLE && pick == OWN_CPU)
            starve_d = 4'd0;
        else if (state_q == S_IDLE && pick == OWN_VID && starve_q != STARVE_LIM)
            starve_d = starve_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                if (pick != OWN_NONE) begin
                    owner_d = pick;
                    state_d = S_ISSUE;
                    case (pick)
                        OWN_LD: begin
                            we_d   = 1'b1;
                            addr_d = ADDR_BASE + {5'd0, ld_addr[26:3]};
                            din_d  = {4{ld_data}};
                            be_d   = 8'h03 << {ld_addr[2:1], 1'b0};
                        end
                        OWN_VID: begin
                            rd_d   = 1'b1;
                            addr_d = ADDR_BASE + vid_addr;
                            be_d   = 8'hFF;
                        end
                        default: begin
                            rd_d   = 1'b1;
                            addr_d = ADDR_BASE + cpu_addr;
                            be_d   = 8'hFF;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (!ddram_busy) begin
                    rd_d = 1'b0;
                    we_d = 1'b0;
                    if (owner_q == OWN_LD) begin
                        state_d = S_IDLE;
                        owner_d = OWN_NONE;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end
            end
            S_WAIT_RD: begin
                if (ddram_dout_ready) begin
                    if (owner_q == OWN_VID) begin
                        vid_data_d  = ddram_dout;
                        vid_valid_d = 1'b1;
                    end else begin
                        cpu_data_d  = ddram_dout;
                        cpu_valid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= 4'd0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 29'd0;
            din_q       <= 64'd0;
            be_q        <= 8'd0;
            vid_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            vid_data_q  <= 64'd0;
            cpu_data_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            be_q        <= be_d;
            vid_valid_q <= vid_valid_d;
            cpu_valid_q <= cpu_valid_d;
            vid_data_q  <= vid_data_d;
            cpu_data_q  <= cpu_data_d;
        end
    end

    assign ld_ack         = accept && (owner_q == OWN_LD);
    assign vid_ack        = accept && (owner_q == OWN_VID);
    assign cpu_ack        = accept && (owner_q == OWN_CPU);
    assign vid_valid      = vid_valid_q;
    assign cpu_valid      = cpu_valid_q;
    assign vid_data       = vid_data_q;
    assign cpu_data       = cpu_data_q;
    assign ddram_rd       = rd_q;
    assign ddram_we       = we_q;
    assign ddram_addr     = addr_q;
    assign ddram_din      = din_q;
    assign ddram_be       = be_q;
    assign ddram_burstcnt = 8'd1;

endmodule

// File: doc/pgm_ddram_arb.md
Name: pgm_ddram_arb

Overview:
Single-clock arbiter and sequencer for the shared MiSTer DDRAM port in the PGM core. It serves three requesters, one transaction at a time:
- ioctl ROM loader: 16-bit writes.
- Video tile/sprite fetch: 64-bit reads.
- 68000 program-ROM fetch: 64-bit reads.
It replaces the combinational download/video mux with a handshaked, priority-scheduled controller that honours ddram_busy and ddram_dout_ready.

Parameters:
ADDR_BASE, 29'h0600_0000, 64-bit-word base of the PGM region in DDRAM; added to every requester address, modulo 2^29.
STARVE_MAX, 4, consecutive video grants allowed while cpu_req is pending before the CPU is forced to win; range 1..15.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
ld_req  in  1  loader write request; held until ld_ack.
ld_addr  in  27  loader byte address; bit 0 is ignored.
ld_data  in  16  loader write word.
ld_ack  out  1  one-cycle pulse: write accepted by DDRAM.
vid_req  in  1  video read request; held until vid_ack.
vid_addr  in  29  video 64-bit-word offset.
vid_ack  out  1  one-cycle pulse: read command accepted.
vid_valid  out  1  one-cycle pulse: vid_data updated.
vid_data  out  64  last video read data; holds its value between reads.
cpu_req  in  1  CPU read request; held until cpu_ack.
cpu_addr  in  29  CPU 64-bit-word offset.
cpu_ack  out  1  one-cycle pulse: read command accepted.
cpu_valid  out  1  one-cycle pulse: cpu_data updated.
cpu_data  out  64  last CPU read data; holds its value between reads.
ddram_rd  out  1  read command.
ddram_we  out  1  write command.
ddram_addr  out  29  command address.
ddram_din  out  64  write data.
ddram_be  out  8  write byte enables.
ddram_burstcnt  out  8  constant 8'd1.
ddram_busy  in  1  high: command not accepted this cycle.
ddram_dout  in  64  read data.
ddram_dout_ready  in  1  ddram_dout valid this cycle.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; starve counter 0; owner register cleared.
  - ddram_rd, ddram_we, all ack and valid outputs 0.
  - vid_data, cpu_data, ddram_addr, ddram_din, ddram_be all 0.
  - ddram_burstcnt is always 1.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any request is high, select a winner and register owner, address, data and be.
  - Next cycle: state ISSUE with ddram_rd (read) or ddram_we (write) asserted.
  - No request: stay in IDLE with commands low.
- Priority, evaluated in IDLE only:
  1. ld_req.
  2. cpu_req, if starve counter == STARVE_MAX.
  3. vid_req.
  4. cpu_req.
- Starve counter:
  - +1 on each video grant while cpu_req is high, saturating at STARVE_MAX.
  - Cleared on a CPU grant, or in any cycle cpu_req is low.
- ISSUE:
  - Command, address, data and be stay stable while ddram_busy = 1.
  - First cycle with ddram_busy = 0: the command is accepted. Pulse the owner's ack in that same cycle and drop ddram_rd/ddram_we the next cycle.
  - Write: go to IDLE. Read: go to WAIT_RD.
- WAIT_RD:
  - On ddram_dout_ready: capture ddram_dout into the owner's data register, pulse the owner's valid the cycle after capture (data already visible), go to IDLE.
  - Exactly one beat is expected per read.
- ddram_dout_ready in IDLE or ISSUE is ignored (stale data after reset is dropped).
- Requester rule: req, addr and data must stay stable until ack. A req still high in the cycle after ack counts as a new request.
- Loader addressing:
  - ddram_addr = ADDR_BASE + ld_addr[26:3].
  - ddram_din = {4{ld_data}}.
  - ddram_be = 8'h03 << (2*ld_addr[2:1]), giving 03/0C/30/C0.
- Read addressing: ddram_addr = ADDR_BASE + vid_addr or cpu_addr, truncated to 29 bits (wraps); ddram_be = 8'hFF.
- Minimum cycles per transaction with busy low and zero read latency: write 2 (IDLE, ISSUE); read 3.
- A request arriving mid-transaction waits; there is no pre-emption. ld_req raised during a read is served on the next IDLE.
- Simultaneous ack and valid for different owners cannot occur; only one transaction is in flight.

Test Plan:
- Loader write, ld_addr = 27'h000_0014, ld_data = 16'hBEEF, busy low:
  - ddram_we = 1, ddram_addr = 29'h0600_0002, ddram_be = 8'h30, ddram_din = 64'hBEEF_BEEF_BEEF_BEEF.
  - ld_ack is one cycle; we is high for exactly one cycle.
- Busy stall: vid_req with vid_addr = 29'h10, ddram_busy high for 5 cycles:
  - ddram_rd and ddram_addr = 29'h0600_0010 held for 6 cycles.
  - vid_ack on the 6th; dout_ready 2 cycles later with data 64'h0123_4567_89AB_CDEF.
  - vid_data equals that value and vid_valid pulses once.
- Starvation: vid_req and cpu_req both held continuously, STARVE_MAX = 4:
  - Grant order V,V,V,V,C,V,V,V,V,C.
  - cpu_valid carries the correct data each time.
- Loader priority: ld_req, vid_req and cpu_req rise in the same cycle -> loader granted first, then video, then CPU; no command overlap.
- Reset mid-read: assert reset_n = 0 in WAIT_RD, release, then pulse ddram_dout_ready:
  - No valid pulse.
  - All outputs 0 during reset.
  - The next vid_req completes normally.
- Address wrap: ADDR_BASE = 29'h1FFF_FFF0, cpu_addr = 29'h20 -> ddram_addr = 29'h0000_0010.
